// File: rtl/pagerank_pkg.sv
// Shared types for the PageRank scatter block: FSM states, Q32.32 rank type, and
// node/edge index types.
package pagerank_pkg;

    localparam int RANK_FRAC_BITS = 32;

    typedef logic [63:0] rank_t;
    typedef logic [31:0] node_id_t;
    typedef logic [31:0] edge_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        EMIT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pagerank_divider.sv
// 64/32 unsigned restoring divider. It produces one quotient bit per cycle.
// done pulses 64 cycles after an accepted start.
module pagerank_divider
    import pagerank_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  rank_t       dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output rank_t       quotient
);

    logic        busy;
    logic [5:0]  step;
    logic [31:0] rem;
    logic [31:0] divisor_q;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;

    always_comb begin
        rem_shift = {rem, quotient[63]};
        rem_diff  = rem_shift - {1'b0, divisor_q};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            step <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy <= 1'b1;
                step <= '0;
            end else if (busy) begin
                step <= step + 6'd1;
                if (step == 6'd63) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // The remainder stays below the divisor, so 32 bits are enough once the shift-in is compared at 33.
    always_ff @(posedge clock) begin
        if (start && !busy) begin
            rem       <= '0;
            divisor_q <= divisor;
            quotient  <= dividend;
        end else if (busy) begin
            if (rem_shift >= {1'b0, divisor_q}) begin
                rem      <= rem_diff[31:0];
                quotient <= {quotient[62:0], 1'b1};
            end else begin
                rem      <= rem_shift[31:0];
                quotient <= {quotient[62:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/pagerank_scatter.sv
// PageRank scatter: walks the CSR graph and divides each node's rank by its out-degree.
// It then emits one contribution per out-edge. PAGERANK_SCATTER_PERF_EN adds an edges_emitted counter.
module pagerank_scatter
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_GRAPH = 32
)
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      start,
    input  rank_t     pagerank_current [NODES_IN_GRAPH],
    input  edge_idx_t row_offset [NODES_IN_GRAPH+1],
    output logic      col_rd_en,
    output edge_idx_t col_addr,
    input  node_id_t  col_data,
    output rank_t     page_rank_scatter,
    output node_id_t  dest_id,
    output logic      pagerank_ready,
    output logic      scatter_operation_complete
`ifdef PAGERANK_SCATTER_PERF_EN
    ,
    output logic [31:0] edges_emitted
`endif
);

    localparam int NW = $clog2(NODES_IN_GRAPH + 1);
    localparam int RW = $clog2(NODES_IN_GRAPH);
    localparam logic [NW-1:0] LAST_NODE = NW'(NODES_IN_GRAPH - 1);

    state_t        state, state_nxt;
    logic [NW-1:0] node, node_nxt;
    edge_idx_t     edge_idx, edge_nxt;
    edge_idx_t     off_lo, off_hi, deg;
    rank_t         contrib;
    rank_t         div_q;
    logic          div_start, div_done;
    logic          last_node, last_edge;
    logic          vld_p1;

    always_comb begin
        off_lo    = row_offset[node];
        off_hi    = row_offset[node + NW'(1)];
        deg       = (off_hi > off_lo) ? off_hi - off_lo : '0;
        last_node = (node == LAST_NODE);
        last_edge = (edge_idx == off_hi - 32'd1);
    end

    always_comb begin
        state_nxt = state;
        node_nxt  = node;
        edge_nxt  = edge_idx;
        div_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    node_nxt  = '0;
                end
            end
            LOAD: begin
                if (deg == '0) begin
                    if (last_node) state_nxt = DRAIN;
                    else           node_nxt  = node + NW'(1);
                end else begin
                    div_start = 1'b1;
                    state_nxt = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    state_nxt = EMIT;
                    edge_nxt  = off_lo;
                end
            end
            EMIT: begin
                if (last_edge) begin
                    if (last_node) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = LOAD;
                        node_nxt  = node + NW'(1);
                    end
                end else begin
                    edge_nxt = edge_idx + 32'd1;
                end
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            node     <= '0;
            edge_idx <= '0;
            contrib  <= '0;
        end else begin
            state    <= state_nxt;
            node     <= node_nxt;
            edge_idx <= edge_nxt;
            if (state == DIVIDE && div_done) contrib <= div_q;
        end
    end

    pagerank_divider u_divider (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (pagerank_current[node[RW-1:0]]),
        .divisor  (deg),
        .done     (div_done),
        .quotient (div_q)
    );

    // p0 -> p1: edge read issued, destination id returns next cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_p1 <= 1'b0;
        else          vld_p1 <= col_rd_en;
    end

    assign col_rd_en                  = (state == EMIT);
    assign col_addr                   = col_rd_en ? edge_idx : '0;
    assign pagerank_ready             = vld_p1;
    assign dest_id                    = vld_p1 ? col_data : '0;
    assign page_rank_scatter          = vld_p1 ? contrib : '0;
    assign scatter_operation_complete = (state == DONE);

`ifdef PAGERANK_SCATTER_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            edges_emitted <= '0;
        else if ((state == IDLE || state == DONE) && start)
            edges_emitted <= '0;
        else if (vld_p1 && edges_emitted != 32'hFFFF_FFFF)
            edges_emitted <= edges_emitted + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pagerank_scatter.sv
// Directed bench for pagerank_scatter on a 4-node graph with hand-computed contributions.
module tb_pagerank_scatter;
    import pagerank_pkg::*;

    localparam int N = 4;
    localparam logic [63:0] ONE  = 64'd1 << RANK_FRAC_BITS;
    localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [63:0] rank [N];
    logic [31:0] offs [N+1];
    logic        col_rd_en;
    logic [31:0] col_addr;
    logic [31:0] col_data;
    logic [63:0] page_rank_scatter;
    logic [31:0] dest_id;
    logic        pagerank_ready;
    logic        scatter_operation_complete;
`ifdef PAGERANK_SCATTER_PERF_EN
    logic [31:0] edges_emitted;
`endif

    logic [31:0] col_mem [8];
    logic [95:0] got_q [$];
    logic [95:0] exp_q [$];
    int          rd_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          base_cyc;
    int          cyc;
    int          seen;

    always #5 clock = ~clock;

    pagerank_scatter #(.NODES_IN_GRAPH(N)) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .start                      (start),
        .pagerank_current           (rank),
        .row_offset                 (offs),
        .col_rd_en                  (col_rd_en),
        .col_addr                   (col_addr),
        .col_data                   (col_data),
        .page_rank_scatter          (page_rank_scatter),
        .dest_id                    (dest_id),
        .pagerank_ready             (pagerank_ready),
        .scatter_operation_complete (scatter_operation_complete)
`ifdef PAGERANK_SCATTER_PERF_EN
        ,
        .edges_emitted              (edges_emitted)
`endif
    );

    // Edge memory with one cycle of read latency
    always @(posedge clock) col_data <= col_rd_en ? col_mem[col_addr[2:0]] : 32'd0;

    always @(negedge clock) begin
        if (col_rd_en) rd_cnt++;
        if (pagerank_ready) got_q.push_back({dest_id, page_rank_scatter});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_complete(input string tag, output int cycles);
        cycles = 1;
        while (!scatter_operation_complete && cycles < 3000) begin
            @(negedge clock);
            cycles++;
        end
        chk({tag, "_done"}, 64'(scatter_operation_complete), 64'd1);
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, "_pulses"}, 64'(got_q.size()), 64'(exp_q.size()));
        chk({tag, "_reads"}, 64'(rd_cnt), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("%s_dest%0d", tag, i), 64'(got_q[i][95:64]), 64'(exp_q[i][95:64]));
                chk($sformatf("%s_rank%0d", tag, i), got_q[i][63:0], exp_q[i][63:0]);
            end
        end
    endtask

    task automatic run_pass(input string tag, output int cycles);
        got_q.delete();
        rd_cnt = 0;
        pulse_start();
        wait_complete(tag, cycles);
        check_pulses(tag);
    endtask

    task automatic cfg_basic();
        for (int i = 0; i < N; i++) rank[i] = ONE;
        offs = '{32'd0, 32'd2, 32'd3, 32'd3, 32'd4};
        col_mem = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        exp_q.delete();
        exp_q.push_back({32'd1, HALF});
        exp_q.push_back({32'd2, HALF});
        exp_q.push_back({32'd0, ONE});
        exp_q.push_back({32'd1, ONE});
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        rd_cnt  = 0;
        for (int i = 0; i < N; i++) rank[i] = '0;
        for (int i = 0; i <= N; i++) offs[i] = '0;
        for (int i = 0; i < 8; i++) col_mem[i] = '0;

        repeat (3) @(negedge clock);
        chk("rst_rd_en", 64'(col_rd_en), 64'd0);
        chk("rst_addr", 64'(col_addr), 64'd0);
        chk("rst_ready", 64'(pagerank_ready), 64'd0);
        chk("rst_dest", 64'(dest_id), 64'd0);
        chk("rst_rank", page_rank_scatter, 64'd0);
        chk("rst_complete", 64'(scatter_operation_complete), 64'd0);
`ifdef PAGERANK_SCATTER_PERF_EN
        chk("rst_edges", 64'(edges_emitted), 64'd0);
`endif
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("idle_complete", 64'(scatter_operation_complete), 64'd0);
        chk("idle_reads", 64'(rd_cnt), 64'd0);

        // Basic graph: node 2 has no out-edges
        cfg_basic();
        run_pass("basic", base_cyc);
`ifdef PAGERANK_SCATTER_PERF_EN
        chk("perf_done", 64'(edges_emitted), 64'd4);
`endif

        // Mixed ranks: 1/3, 7/2 and the all-ones rank divided by 1
        rank = '{ONE, 64'h0000_0009_0000_0000, 64'h0000_0007_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        offs = '{32'd0, 32'd3, 32'd3, 32'd5, 32'd6};
        col_mem = '{32'd2, 32'd3, 32'd1, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0};
        exp_q.delete();
        exp_q.push_back({32'd2, 64'h0000_0000_5555_5555});
        exp_q.push_back({32'd3, 64'h0000_0000_5555_5555});
        exp_q.push_back({32'd1, 64'h0000_0000_5555_5555});
        exp_q.push_back({32'd0, 64'h0000_0003_8000_0000});
        exp_q.push_back({32'd3, 64'h0000_0003_8000_0000});
        exp_q.push_back({32'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        run_pass("mixed", cyc);

        // No edges at all
        for (int i = 0; i <= N; i++) offs[i] = '0;
        exp_q.delete();
        run_pass("empty", cyc);
        chk("empty_latency_ok", 64'(cyc <= N + 2), 64'd1);

        // Reset while the second edge read is on the bus
        cfg_basic();
        got_q.delete();
        rd_cnt = 0;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 3000 && seen < 2; i++) begin
            @(negedge clock);
            if (col_rd_en) seen++;
        end
        chk("mid_reached_2nd_read", 64'(seen), 64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", 64'(col_rd_en), 64'd0);
        chk("mid_rst_ready", 64'(pagerank_ready), 64'd0);
        chk("mid_rst_rank", page_rank_scatter, 64'd0);
        chk("mid_rst_dest", 64'(dest_id), 64'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        chk("mid_pulses", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) chk("mid_first", got_q[0], {32'd1, HALF});
        chk("mid_idle_complete", 64'(scatter_operation_complete), 64'd0);
        run_pass("replay", cyc);
        chk("replay_cycles", 64'(cyc), 64'(base_cyc));

        // Start during DIVIDE is ignored, so the pass length is unchanged
        got_q.delete();
        rd_cnt = 0;
        pulse_start();
        repeat (10) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_complete("ign", cyc);
        check_pulses("ign");
        chk("ign_cycles", 64'(cyc + 11), 64'(base_cyc));

        // Start from DONE clears complete and repeats the pass
        got_q.delete();
        rd_cnt = 0;
        pulse_start();
        chk("redo_complete_cleared", 64'(scatter_operation_complete), 64'd0);
`ifdef PAGERANK_SCATTER_PERF_EN
        chk("perf_cleared", 64'(edges_emitted), 64'd0);
`endif
        wait_complete("redo", cyc);
        check_pulses("redo");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
